// File: rtl/uart_line_receiver.sv
// Line framer: gathers received UART bytes into a working buffer and publishes a frame
// on CR LF, on buffer full or after the line has been idle for IDLE_CHARS character times.
module uart_line_receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int MAX_LEN    = 128,
    parameter int IDLE_CHARS = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [MAX_LEN*8-1:0] rx_string,
    output logic [7:0]           rx_length,
    output logic [1:0]           rx_cause,
    output logic                 rx_busy,
    output logic                 rx_done
);

    localparam int TIMEOUT_CYC = (CLK_FREQ / BAUD_RATE) * 10 * IDLE_CHARS;
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam logic [1:0] CAUSE_CRLF = 2'b00;
    localparam logic [1:0] CAUSE_IDLE = 2'b01;
    localparam logic [1:0] CAUSE_FULL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN*8-1:0] buf_q, buf_d;
    logic [MAX_LEN*8-1:0] wr_buf;
    logic [MAX_LEN*8-1:0] pub_str;
    logic [7:0]           count_q, count_d;
    logic                 cr_q, cr_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic                 wr_en;
    logic                 crlf_hit;
    logic                 pub_en;
    logic [7:0]           pub_len;
    logic [1:0]           pub_cause;

    logic [MAX_LEN*8-1:0] rx_string_q;
    logic [7:0]           rx_length_q;
    logic [1:0]           rx_cause_q;

    // count_q is 0 outside RECV, so the write lane is always selected by count_q.
    assign crlf_hit = (state_q == S_RECV) && (rx_data == CHAR_LF) && cr_q;
    assign wr_en    = rx_valid && !crlf_hit;

    // Frame published from wr_buf masked to pub_len: drops the CR slot and unused bytes.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_lane
        assign wr_buf[gi*8 +: 8]  = (wr_en && (count_q == 8'(gi))) ? rx_data : buf_q[gi*8 +: 8];
        assign pub_str[gi*8 +: 8] = (8'(gi) < pub_len) ? wr_buf[gi*8 +: 8] : 8'h00;
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = wr_buf;
        count_d   = count_q;
        cr_d      = cr_q;
        idle_d    = idle_q;
        pub_en    = 1'b0;
        pub_len   = count_q;
        pub_cause = CAUSE_CRLF;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                idle_d  = '0;
                if (rx_valid) begin
                    count_d = 8'd1;
                    cr_d    = (rx_data == CHAR_CR);
                    state_d = S_RECV;
                end
            end

            S_RECV: begin
                if (rx_valid) begin
                    idle_d = '0;
                    if (crlf_hit) begin
                        buf_d   = '0;
                        count_d = 8'd0;
                        cr_d    = 1'b0;
                        if (count_q != 8'd1) begin
                            pub_en    = 1'b1;
                            pub_len   = count_q - 8'd1;
                            pub_cause = CAUSE_CRLF;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (count_q + 8'd1 == 8'(MAX_LEN)) begin
                        pub_en    = 1'b1;
                        pub_len   = count_q + 8'd1;
                        pub_cause = CAUSE_FULL;
                        buf_d     = '0;
                        count_d   = 8'd0;
                        cr_d      = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        count_d = count_q + 8'd1;
                        cr_d    = (rx_data == CHAR_CR);
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    pub_en    = 1'b1;
                    pub_len   = count_q;
                    pub_cause = CAUSE_IDLE;
                    buf_d     = '0;
                    count_d   = 8'd0;
                    cr_d      = 1'b0;
                    idle_d    = '0;
                    state_d   = S_DONE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                buf_d   = '0;
                count_d = 8'd0;
                cr_d    = 1'b0;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            count_q     <= 8'd0;
            cr_q        <= 1'b0;
            idle_q      <= '0;
            rx_string_q <= '0;
            rx_length_q <= 8'd0;
            rx_cause_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            cr_q    <= cr_d;
            idle_q  <= idle_d;
            if (pub_en) begin
                rx_string_q <= pub_str;
                rx_length_q <= pub_len;
                rx_cause_q  <= pub_cause;
            end
        end
    end

    assign rx_string = rx_string_q;
    assign rx_length = rx_length_q;
    assign rx_cause  = rx_cause_q;
    assign rx_busy   = (state_q == S_RECV);
    assign rx_done   = (state_q == S_DONE);

endmodule
